// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the r200 pipeline sequencer: FSM states, writeback
// select codes and the load-use hazard predicate.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // A load in EX whose destination is read by the instruction in ID.
  // Writes to x0 never create a hazard.
  function automatic logic is_load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2,
    input logic [4:0] rd,
    input logic       regwr,
    input logic [1:0] wbsel
  );
    return regwr && (wbsel == WB_MEM) && (rd != 5'd0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Clear wins over increment; the count never wraps.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage r200 pipeline: boot hold, redirects,
// load-use stalls and data-memory waits, plus saturating perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwr,
  input  logic [1:0]       ex_wbsel,
  input  logic             id_willjmp,
  input  logic             ex_willbr,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_rst,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        cur, nxt;
  logic [BW-1:0] boot_cnt;
  logic [WW-1:0] wait_cnt;
  logic          redirect;
  logic          load_use;

  assign state    = cur;
  assign load_use = is_load_use(id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
                                ex_rd, ex_regwr, ex_wbsel);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= ST_BOOT;
    else     cur <= nxt;
  end

  // Boot window: counts BOOT clocks, then stops at the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         boot_cnt <= '0;
    else if ((cur == ST_BOOT) && (boot_cnt != BOOT_LAST)) boot_cnt <= boot_cnt + 1'b1;
  end

  // Sticky timeout flag; only a reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               mem_err <= 1'b0;
    else if (nxt == ST_ERR) mem_err <= 1'b1;
  end

  // Next state and Mealy stage controls, in RUN priority order.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    nxt           = cur;
    pc_rst        = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_bubble = 1'b0;
    redirect      = 1'b0;
    unique case (cur)
      ST_BOOT: begin
        pc_rst        = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        mem_wb_bubble = 1'b1;
        if (boot_cnt == BOOT_LAST) nxt = ST_RUN;
      end
      ST_RUN, ST_MEMWAIT: begin
        if (mem_req && !mem_ack) begin
          // Memory not ready: freeze the front of the pipe, drain MEM/WB.
          mem_wb_bubble = 1'b1;
          if (cur == ST_RUN)              nxt = ST_MEMWAIT;
          else if (wait_cnt == WAIT_LAST) nxt = ST_ERR;
        end else begin
          nxt       = ST_RUN;
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          if (ex_willbr) begin
            // Kill both younger instructions; a pending load-use dies with them.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            redirect     = 1'b1;
          end else if (id_willjmp) begin
            if_id_flush = 1'b1;
            redirect    = 1'b1;
          end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      end
      ST_ERR: begin
        mem_wb_bubble = 1'b1;
      end
    endcase
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((cur != ST_BOOT) && !pc_en),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .clr (1'b0),
    .q   (flush_cnt)
  );

  // Counts unacknowledged MEMWAIT cycles; zero on every entry.
  sat_cnt #(.W(WW)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((cur == ST_MEMWAIT) && mem_req && !mem_ack),
    .clr (cur != ST_MEMWAIT),
    .q   (wait_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized
// traffic, all compared against a behavioural model of the sequencer.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int BOOT = 4;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_regwr;
  logic [1:0]    ex_wbsel;
  logic          id_willjmp, ex_willbr, mem_req, mem_ack;
  logic          pc_rst, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic          ex_mem_en, mem_wb_bubble, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state;

  pipe_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_wbsel(ex_wbsel),
    .id_willjmp(id_willjmp), .ex_willbr(ex_willbr), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_rst(pc_rst), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: clocks left in boot, waiting flag and cycles waited,
  // frozen-forever flag, and the two perf counts.
  int boot_left, waited, m_stall, m_flush;
  bit waiting, dead, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctl_vec();
    return {pc_rst, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble};
  endfunction

  function automatic bit m_load_use();
    if (!ex_regwr || ex_wbsel != WB_MEM || ex_rd == 5'd0) return 1'b0;
    return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
  endfunction

  // Expected {pc_rst,pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_bubble,ex_mem_en,mem_wb_bubble}.
  function automatic logic [7:0] exp_ctl();
    if (boot_left > 0)            return 8'b1001_0101;
    if (dead)                     return 8'b0000_0001;
    if (mem_req && !mem_ack)      return 8'b0000_0001;
    if (ex_willbr)                return 8'b0111_1110;
    if (id_willjmp)               return 8'b0111_1010;
    if (m_load_use())             return 8'b0000_1110;
    return 8'b0110_1010;
  endfunction

  function automatic int exp_state();
    if (boot_left > 0) return 0;
    if (dead)          return 3;
    if (waiting)       return 2;
    return 1;
  endfunction

  function automatic void model_reset();
    boot_left = BOOT; waited = 0; waiting = 0; dead = 0;
    m_err = 0; m_stall = 0; m_flush = 0;
  endfunction

  function automatic void model_advance();
    logic [7:0] c;
    c = exp_ctl();
    if (boot_left > 0) begin
      boot_left--;
    end else begin
      if (!c[6] && m_stall < CMAX) m_stall++;
      if (!dead) begin
        if (mem_req && !mem_ack) begin
          if (!waiting) begin
            waiting = 1; waited = 0;
          end else begin
            waited++;
            if (waited == TMO) begin dead = 1; m_err = 1; waiting = 0; end
          end
        end else begin
          waiting = 0;
          if ((ex_willbr || id_willjmp) && m_flush < CMAX) m_flush++;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ":ctl"},   32'(ctl_vec()),  32'(exp_ctl()));
    check({tag, ":state"}, 32'(state),      32'(exp_state()));
    check({tag, ":stall"}, 32'(stall_cnt),  32'(m_stall));
    check({tag, ":flush"}, 32'(flush_cnt),  32'(m_flush));
    check({tag, ":err"},   32'(mem_err),    32'(m_err));
  endtask

  // One clock: compare at the falling edge, then advance model and DUT together.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_regwr = 0; ex_wbsel = WB_ALU;
    id_willjmp = 0; ex_willbr = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Assert rst between edges, check the immediate effect, release off-edge.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom_range(0, 1));
    id_uses_rs2 = 1'($urandom_range(0, 1));
    ex_regwr    = 1'($urandom_range(0, 1));
    ex_wbsel    = 2'($urandom_range(0, 3));
    ex_willbr   = ($urandom_range(0, 7) == 0);
    id_willjmp  = ($urandom_range(0, 5) == 0);
    mem_req     = ($urandom_range(0, 3) == 0);
    mem_ack     = mem_req && ($urandom_range(0, 1) == 0);
  endtask

  initial begin
    set_idle();
    #3;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Boot window: pc_rst high for BOOT clocks, pc_en on the next one.
    repeat (BOOT) step("boot");
    check("boot_pc_rst_low", 32'(pc_rst), 32'd0);
    check("boot_pc_en",      32'(pc_en),  32'd1);
    step("run_idle");

    // lw x5 in EX, add x6,x5,x1 in ID.
    ex_rd = 5'd5; ex_regwr = 1; ex_wbsel = WB_MEM;
    id_rs1 = 5'd5; id_uses_rs1 = 1; id_rs2 = 5'd1; id_uses_rs2 = 1;
    step("load_use");
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    step("lu_x0");
    check("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Taken branch overrides a simultaneous load-use.
    ex_rd = 5'd5; id_rs1 = 5'd5; ex_willbr = 1;
    step("br_over_lu");
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    set_idle(); id_willjmp = 1;
    step("jump");
    check("jmp_flush_cnt", 32'(flush_cnt), 32'd2);

    // Ack after three frozen cycles.
    set_idle(); mem_req = 1;
    repeat (3) step("memwait");
    mem_ack = 1;
    step("mem_ack");
    check("mw_stall_cnt", 32'(stall_cnt), 32'd4);
    check("mw_resume",    32'(state),     32'd1);

    // Ack at the last legal wait count still succeeds.
    set_idle(); mem_req = 1;
    repeat (TMO) step("tmo_edge");
    mem_ack = 1;
    step("tmo_edge_ack");
    check("tmo_edge_state", 32'(state), 32'd1);

    // No ack: timeout into ERR, frozen afterwards.
    set_idle(); mem_req = 1;
    repeat (TMO + 1) step("tmo");
    check("err_flag", 32'(mem_err), 32'd1);
    set_idle();
    repeat (3) step("err_frozen");

    // Async reset in the middle of a memory wait.
    apply_reset("rst_err");
    repeat (BOOT) step("reboot");
    mem_req = 1;
    repeat (2) step("pre_rst_wait");
    apply_reset("rst_mid_wait");
    set_idle();
    repeat (BOOT) step("reboot2");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ((dead && $urandom_range(0, 9) == 0) || $urandom_range(0, 399) == 0)
        apply_reset("rand_rst");
      randomize_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
